// File: rtl/joy_scan_pkg.sv
// Shared types and constants for the joystick shift-register scanner.
// Build macro JOY_SCAN_INVERT_EN selects pressed=1 polarity for the debounced vector.
package joy_scan_pkg;

  localparam int unsigned NBITS_DEF    = 16;
  localparam int unsigned DIV_W_DEF    = 8;
  localparam int unsigned DEBOUNCE_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_DONE
  } scan_state_e;

`ifdef JOY_SCAN_INVERT_EN
  localparam logic JOY_INV     = 1'b1;
  localparam logic JOY_RST_BIT = 1'b0;
`else
  localparam logic JOY_INV     = 1'b0;
  localparam logic JOY_RST_BIT = 1'b1;
`endif

  // Width of a saturating counter that must reach deb.
  function automatic int unsigned cnt_width(input int unsigned deb);
    return (deb < 2) ? 1 : $clog2(deb + 1);
  endfunction

endpackage

// File: rtl/joy_scan_if.sv
// Core- and chain-side signals of the joystick scanner.
// master = scanner, slave = core plus external chain.
interface joy_scan_if
  import joy_scan_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF
);

  logic             enable;
  logic             scan_req;
  logic [DIV_W-1:0] divisor;
  logic             joy_data;
  logic             joy_clk;
  logic             joy_load_n;
  logic [NBITS-1:0] joy_state;
  logic             frame_valid;
  logic             changed;
  logic             busy;

  modport master (
    input  enable, scan_req, divisor, joy_data,
    output joy_clk, joy_load_n, joy_state, frame_valid, changed, busy
  );

  modport slave (
    output enable, scan_req, divisor, joy_data,
    input  joy_clk, joy_load_n, joy_state, frame_valid, changed, busy
  );

endinterface

// File: rtl/joy_scan_tick.sv
// Reloadable tick divider: tick_c fires every div_lat+1 cycles after a restart.
module joy_scan_tick
  import joy_scan_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [DIV_W-1:0] div_lat,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt;

  assign tick_c = (cnt == div_lat);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/joy_scan_ctrl.sv
// Joystick chain sequencer: load pulse, shift clock, frame capture and frame debounce.
// Polarity of joy_state follows build macro JOY_SCAN_INVERT_EN.
module joy_scan_ctrl
  import joy_scan_pkg::*;
#(
  parameter int unsigned NBITS    = NBITS_DEF,
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
) (
  input logic       clk,
  input logic       reset,
  joy_scan_if.master bus
);

  localparam int unsigned IDX_W = $clog2(NBITS);
  localparam int unsigned CNT_W = cnt_width(DEBOUNCE);
  localparam logic [NBITS-1:0] RST_VEC = {NBITS{JOY_RST_BIT}};

  scan_state_e      state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [NBITS-1:0] raw, raw_nxt;
  logic [NBITS-1:0] prev_raw;
  logic [CNT_W-1:0] stable_cnt, cnt_nxt;
  logic [DIV_W-1:0] div_lat;
  logic             load_div;
  logic             enter_done;
  logic             upd;
  logic             restart;
  logic             tick_c;

  logic             joy_clk_q;
  logic             joy_load_n_q;
  logic [NBITS-1:0] joy_state_q;
  logic             frame_valid_q;
  logic             changed_q;
  logic             busy_q;

  assign restart = (state == S_IDLE) || (state == S_DONE);

  joy_scan_tick #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .div_lat (div_lat),
    .tick_c  (tick_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sequencing plus frame debounce, evaluated on the cycle that enters DONE.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    raw_nxt    = raw;
    load_div   = 1'b0;
    enter_done = 1'b0;
    cnt_nxt    = stable_cnt;
    upd        = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.enable || bus.scan_req) begin
          state_nxt = S_LOAD;
          load_div  = 1'b1;
        end
      end
      S_LOAD: begin
        if (tick_c) begin
          state_nxt = S_LOW;
          idx_nxt   = '0;
        end
      end
      S_LOW: begin
        if (tick_c) begin
          raw_nxt[idx] = bus.joy_data ^ JOY_INV;
          state_nxt    = S_HIGH;
        end
      end
      S_HIGH: begin
        if (tick_c) begin
          if (idx == IDX_W'(NBITS - 1)) begin
            state_nxt  = S_DONE;
            enter_done = 1'b1;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = S_LOW;
          end
        end
      end
      S_DONE: begin
        if (bus.enable) begin
          state_nxt = S_LOAD;
          load_div  = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (raw_nxt == prev_raw) begin
      cnt_nxt = (stable_cnt < CNT_W'(DEBOUNCE)) ? stable_cnt + CNT_W'(1) : stable_cnt;
    end else begin
      cnt_nxt = CNT_W'(1);
    end
    upd = enter_done && (cnt_nxt >= CNT_W'(DEBOUNCE)) && (raw_nxt != joy_state_q);
  end

  // Datapath and registered outputs, driven from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx           <= '0;
      raw           <= RST_VEC;
      prev_raw      <= RST_VEC;
      stable_cnt    <= '0;
      div_lat       <= '0;
      joy_clk_q     <= 1'b0;
      joy_load_n_q  <= 1'b1;
      joy_state_q   <= RST_VEC;
      frame_valid_q <= 1'b0;
      changed_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      idx           <= idx_nxt;
      raw           <= raw_nxt;
      joy_clk_q     <= (state_nxt == S_HIGH);
      joy_load_n_q  <= (state_nxt != S_LOAD);
      busy_q        <= (state_nxt != S_IDLE);
      frame_valid_q <= enter_done;
      changed_q     <= upd;
      if (load_div) begin
        div_lat <= bus.divisor;
      end
      if (enter_done) begin
        prev_raw   <= raw_nxt;
        stable_cnt <= cnt_nxt;
      end
      if (upd) begin
        joy_state_q <= raw_nxt;
      end
    end
  end

  assign bus.joy_clk     = joy_clk_q;
  assign bus.joy_load_n  = joy_load_n_q;
  assign bus.joy_state   = joy_state_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.changed     = changed_q;
  assign bus.busy        = busy_q;

endmodule
